// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises the serial line, samples each bit at its
// centre using oversample ticks, and hands bytes out over valid/ready.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int CNT_W      = $clog2(OVERSAMPLE)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 rx_os_clk,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 rx_busy
);

  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state, state_nx;
  logic [CNT_W-1:0]     cnt, cnt_nx;
  logic [BIT_W-1:0]     bitn, bitn_nx;
  logic [DATA_BITS-1:0] shift, shift_nx;
  logic                 sync_p0, sync_p1, os_p0, last_rx_s;
  logic                 rx_s, tick;
  logic                 deliver, frame_err_nx, overrun_nx;

  assign rx_s    = sync_p1;
  assign tick    = rx_os_clk & ~os_p0;
  assign rx_busy = (state != IDLE);

  // Stage boundary: line synchroniser, tick edge detect, FSM and output registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_p0      <= 1'b1;
      sync_p1      <= 1'b1;
      os_p0        <= 1'b0;
      last_rx_s    <= 1'b1;
      state        <= IDLE;
      cnt          <= '0;
      bitn         <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      sync_p0      <= rx_in;
      sync_p1      <= sync_p0;
      os_p0        <= rx_os_clk;
      if (tick) last_rx_s <= rx_s;
      state        <= state_nx;
      cnt          <= cnt_nx;
      bitn         <= bitn_nx;
      rx_frame_err <= frame_err_nx;
      rx_overrun   <= overrun_nx;
      // A fresh byte wins over an acceptance on the same edge
      if (deliver) begin
        rx_data  <= shift;
        rx_valid <= 1'b1;
      end else if (rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    shift <= shift_nx;
  end

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    bitn_nx      = bitn;
    shift_nx     = shift;
    deliver      = 1'b0;
    frame_err_nx = 1'b0;
    overrun_nx   = 1'b0;
    if (tick) begin
      case (state)
        IDLE: begin
          // Falling edge only, so a held-low break cannot retrigger
          if (!rx_s && last_rx_s) begin
            state_nx = START;
            cnt_nx   = '0;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt_nx   = '0;
            bitn_nx  = '0;
            state_nx = rx_s ? IDLE : DATA;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt_nx   = '0;
            shift_nx = {rx_s, shift[DATA_BITS-1:1]};
            if (bitn == DATA_LAST) state_nx = STOP;
            else                   bitn_nx  = bitn + 1'b1;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt_nx   = '0;
            state_nx = IDLE;
            if (!rx_s)                     frame_err_nx = 1'b1;
            else if (rx_valid && !rx_ready) overrun_nx  = 1'b1;
            else                           deliver      = 1'b1;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

endmodule
